iob_fifo2axis: RTL and testbench



---
 rtl/iob_fifo2axis.sv | 117 +++++++++++
 tb/tb_iob_fifo2axis.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo2axis.sv
// FIFO-to-AXI-Stream drain stage: issues FIFO reads, absorbs the one-cycle read latency
// and buffers up to two words. Optional TLAST/done generation under IOB_FIFO2AXIS_TLAST_EN.
module iob_fifo2axis #(
    parameter int DATA_W = 21,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              fifo_r_en_o,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_r_data_i,
    output logic              axis_tvalid_o,
    input  logic              axis_tready_i,
    output logic [DATA_W-1:0] axis_tdata_o,
    output logic              axis_tlast_o,
    output logic              done_o
);

    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic              pop;
    logic [2:0]        credit;
    logic [1:0]        keep;

    assign axis_tvalid_o = (occ_q != 2'd0);
    assign axis_tdata_o  = buf0_q;
    assign pop           = axis_tvalid_o & axis_tready_i;

    // Words owned after this edge, before the next capture: buffered + in flight - leaving.
    assign credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign keep   = occ_q - {1'b0, pop};

    // Gated by reset too, so no FIFO word is consumed only to be discarded.
    assign fifo_r_en_o = cke_i & arst_n_i & ~rst_i & en_i & ~fifo_empty_i & (credit < 3'd2);

    always_comb begin
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        inflight_d = fifo_r_en_o;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (inflight_q) begin
            if (keep == 2'd0) begin
                buf0_d = fifo_r_data_i;
            end else begin
                buf1_d = fifo_r_data_i;
            end
        end
        if (rst_i) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            buf0_d     = '0;
            buf1_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else if (cke_i) begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef IOB_FIFO2AXIS_TLAST_EN
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    assign axis_tlast_o = (len_i != '0) & (cnt_q == (len_i - LEN_ONE)) & axis_tvalid_o;
    assign done_o       = done_q;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = pop & axis_tlast_o;
        if (pop) begin
            cnt_d = axis_tlast_o ? '0 : (cnt_q + LEN_ONE);
        end
        if (rst_i) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (cke_i) begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end
`else
    logic unused_len;

    assign unused_len   = ^len_i;
    assign axis_tlast_o = 1'b0;
    assign done_o       = 1'b0;
`endif

endmodule

// File: tb/tb_iob_fifo2axis.sv
// Bench for iob_fifo2axis: FIFO model with registered read data, queue-based reference
// model of the stream (order, latency, credit, TLAST), vector table and corner sequences.
module tb_iob_fifo2axis;

    localparam int DW = 21;
    localparam int LW = 16;

    logic          clk_i = 1'b0;
    logic          arst_n_i;
    logic          cke_i;
    logic          rst_i;
    logic          en_i;
    logic [LW-1:0] len_i;
    logic          fifo_r_en_o;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_r_data_i;
    logic          axis_tvalid_o;
    logic          axis_tready_i;
    logic [DW-1:0] axis_tdata_o;
    logic          axis_tlast_o;
    logic          done_o;

    iob_fifo2axis #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .cke_i        (cke_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .len_i        (len_i),
        .fifo_r_en_o  (fifo_r_en_o),
        .fifo_empty_i (fifo_empty_i),
        .fifo_r_data_i(fifo_r_data_i),
        .axis_tvalid_o(axis_tvalid_o),
        .axis_tready_i(axis_tready_i),
        .axis_tdata_o (axis_tdata_o),
        .axis_tlast_o (axis_tlast_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] d;
        int            e;
    } ent_t;

    typedef struct {
        logic          tready;
        logic          en;
        logic          exp_ren;
        logic          exp_tv;
        logic          chk_d;
        logic [DW-1:0] exp_d;
    } vec_t;

    ent_t          q[$];        // words read from the FIFO and not yet accepted downstream
    logic [DW-1:0] fifo_q[$];   // contents of the upstream FIFO
    logic [DW-1:0] pop_log[$];
    int            ecnt, pop_idx, tl_cnt, done_cnt, n_tests, n_fail;
    logic          done_m, e_tv, e_tl;
    logic          s_ren, s_tv, s_tl, s_done;
    logic [DW-1:0] s_td;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pop_idx = 0;
        done_m  = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty_i = 1'b0;
    endtask

    // Sample outputs mid-cycle and compare against the reference model.
    task automatic sample_and_check();
        logic e_pop, e_ren;
        @(negedge clk_i);
        s_ren  = fifo_r_en_o;
        s_tv   = axis_tvalid_o;
        s_td   = axis_tdata_o;
        s_tl   = axis_tlast_o;
        s_done = done_o;
        e_tv   = arst_n_i && (q.size() > 0) && (ecnt >= q[0].e + 2);
        e_pop  = e_tv && axis_tready_i;
        e_ren  = cke_i && arst_n_i && !rst_i && en_i && (fifo_q.size() > 0)
                 && ((q.size() - (e_pop ? 1 : 0)) < 2);
`ifdef IOB_FIFO2AXIS_TLAST_EN
        e_tl = e_tv && (len_i != 0) && (((pop_idx + 1) % int'(len_i)) == 0);
`else
        e_tl = 1'b0;
`endif
        check("r_en", s_ren, e_ren);
        check("tvalid", s_tv, e_tv);
        if (e_tv) check("tdata", s_td, q[0].d);
        check("tlast", s_tl, e_tl);
        check("done", s_done, done_m);
        check("read_while_empty", s_ren && fifo_empty_i, 0);
        check("occ_bound", q.size() <= 2, 1);
        if (s_done) done_cnt++;
    endtask

    // Advance one clock and update the FIFO model and reference model.
    task automatic advance();
        logic          got;
        logic [DW-1:0] w;
        got = 1'b0;
        w   = '0;
        @(posedge clk_i);
        if (!arst_n_i) begin
            model_clear();
        end else if (cke_i) begin
            if (rst_i) begin
                model_clear();
            end else begin
                if (s_tv && axis_tready_i) begin
                    pop_log.push_back(s_td);
                    if (s_tl) tl_cnt++;
                    done_m = e_tl;
                    pop_idx++;
                    if (q.size() > 0) q.delete(0);
                end else begin
                    done_m = 1'b0;
                end
                if (s_ren && fifo_q.size() > 0) begin
                    w = fifo_q.pop_front();
                    q.push_back('{d: w, e: ecnt});
                    got = 1'b1;
                end
                ecnt++;
            end
        end
        #1;
        if (got) fifo_r_data_i = w;
        fifo_empty_i = (fifo_q.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sample_and_check();
            advance();
        end
    endtask

    task automatic sync_clear();
        rst_i = 1'b1;
        run(1);
        rst_i = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vt[8];
        int            rcnt, cyc;
        logic [DW-1:0] head;

        vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 21'h0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 21'h0};
        vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 21'h1};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 21'h2};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 21'h3};
        vt[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 21'h4};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 21'h0};
        vt[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 21'h0};

        n_tests = 0; n_fail = 0; ecnt = 0; tl_cnt = 0; done_cnt = 0;
        model_clear();
        arst_n_i = 1'b0; cke_i = 1'b1; rst_i = 1'b0; en_i = 1'b1; len_i = '0;
        fifo_empty_i = 1'b1; fifo_r_data_i = '0; axis_tready_i = 1'b0;

        // Reset state, with a non-empty FIFO present to prove reads are held off.
        push_word(21'h1); push_word(21'h2); push_word(21'h3); push_word(21'h4);
        #2;
        check("rst_r_en", fifo_r_en_o, 0);
        check("rst_tvalid", axis_tvalid_o, 0);
        check("rst_tdata", axis_tdata_o, 0);
        check("rst_tlast", axis_tlast_o, 0);
        check("rst_done", done_o, 0);
        @(posedge clk_i); #1;
        arst_n_i = 1'b1;

        // Basic transfer from the vector table.
        for (int i = 0; i < 8; i++) begin
            axis_tready_i = vt[i].tready;
            en_i          = vt[i].en;
            sample_and_check();
            check($sformatf("vec%0d_r_en", i), s_ren, vt[i].exp_ren);
            check($sformatf("vec%0d_tvalid", i), s_tv, vt[i].exp_tv);
            if (vt[i].chk_d) check($sformatf("vec%0d_tdata", i), s_td, vt[i].exp_d);
            advance();
        end

        // Backpressure: two reads only, head held, then all five drain in order.
        axis_tready_i = 1'b0;
        for (int i = 1; i <= 5; i++) push_word(DW'(i));
        rcnt = 0;
        for (int i = 0; i < 6; i++) begin
            sample_and_check();
            if (s_ren) rcnt++;
            advance();
        end
        sample_and_check();
        check("bp_reads", rcnt, 2);
        check("bp_tvalid", s_tv, 1);
        check("bp_tdata", s_td, 21'h1);
        advance();
        pop_log.delete();
        axis_tready_i = 1'b1;
        run(10);
        check("bp_count", pop_log.size(), 5);
        for (int i = 0; i < 5 && i < pop_log.size(); i++)
            check($sformatf("bp_word%0d", i), pop_log[i], DW'(i + 1));

        // Asynchronous reset with a buffered word and a word in flight.
        axis_tready_i = 1'b0;
        for (int i = 0; i < 6; i++) push_word(DW'(21'h10 + i));
        run(2);
        arst_n_i = 1'b0;
        model_clear();
        #1;
        check("arst_r_en", fifo_r_en_o, 0);
        check("arst_tvalid", axis_tvalid_o, 0);
        check("arst_tdata", axis_tdata_o, 0);
        check("arst_tlast", axis_tlast_o, 0);
        check("arst_done", done_o, 0);
        run(1);
        arst_n_i = 1'b1;
        pop_log.delete();
        axis_tready_i = 1'b1;
        run(10);
        check("arst_count", pop_log.size(), 4);
        if (pop_log.size() > 0) check("arst_first", pop_log[0], 21'h12);

        // Clock-enable freeze mid-stream.
        for (int i = 0; i < 8; i++) push_word(DW'(21'h20 + i));
        run(4);
        cke_i = 1'b0;
        rcnt  = 0;
        head  = '0;
        for (int i = 0; i < 5; i++) begin
            sample_and_check();
            if (i == 0) head = s_td;
            if (s_ren) rcnt++;
            advance();
        end
        check("cke_reads", rcnt, 0);
        cke_i = 1'b1;
        sample_and_check();
        check("cke_head", s_td, head);
        advance();
        run(12);

`ifdef IOB_FIFO2AXIS_TLAST_EN
        // TLAST: len 3 over 7 words, then unbounded.
        len_i = 16'd3;
        sync_clear();
        tl_cnt = 0; done_cnt = 0;
        for (int i = 1; i <= 7; i++) push_word(DW'(21'h30 + i));
        run(14);
        check("tlast_len3", tl_cnt, 2);
        check("done_len3", done_cnt, 2);
        len_i = 16'd0;
        sync_clear();
        tl_cnt = 0; done_cnt = 0;
        for (int i = 1; i <= 7; i++) push_word(DW'(21'h40 + i));
        run(14);
        check("tlast_len0", tl_cnt, 0);
        check("done_len0", done_cnt, 0);
        len_i = 16'd5;
        sync_clear();
`else
        check("tlast_never", tl_cnt, 0);
        check("done_never", done_cnt, 0);
`endif

        // Randomized traffic against the reference model.
        pop_log.delete();
        cyc = 0;
        while (pop_log.size() < 10000 && cyc < 60000) begin
            axis_tready_i = ($urandom_range(0, 99) < 65);
            en_i          = ($urandom_range(0, 99) < 92);
            cke_i         = ($urandom_range(0, 99) < 95);
            rst_i         = ($urandom_range(0, 1999) == 0);
            if (fifo_q.size() < 8 && $urandom_range(0, 99) < 70)
                push_word(DW'($urandom));
            sample_and_check();
            advance();
            cyc++;
        end
        check("random_budget", pop_log.size() >= 10000, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
